// File: rtl/fetch_ctrl_pkg.sv
// Shared types and constants for the instruction fetch controller.
package fetch_ctrl_pkg;

  localparam int unsigned INSTR_W = 16;
  localparam int unsigned ADDR_W  = 16;
  localparam logic [ADDR_W-1:0] PC_INC = 16'd2;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_VALID = 2'd1,
    S_DRAIN = 2'd2,
    S_HALT  = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/fetch_ctrl_if.sv
// Request/acknowledge instruction memory port.
interface fetch_ctrl_if;
  import fetch_ctrl_pkg::*;

  logic               mem_req;
  logic [ADDR_W-1:0]  mem_addr;
  logic               mem_ack;
  logic [INSTR_W-1:0] mem_rdata;

  modport master (output mem_req, output mem_addr, input mem_ack, input mem_rdata);
  modport slave  (input mem_req, input mem_addr, output mem_ack, output mem_rdata);

endinterface

// File: rtl/fetch_ctrl_fulladder16.sv
// 16-bit ripple-carry adder; carry-out is discarded so sums wrap modulo 2^16.
module fulladder16
  import fetch_ctrl_pkg::*;
(
  input  logic [ADDR_W-1:0] a,
  input  logic [ADDR_W-1:0] b,
  input  logic              ci,
  output logic [ADDR_W-1:0] s
);

  logic c;

  always_comb begin
    s = '0;
    c = ci;
    for (int unsigned i = 0; i < ADDR_W; i++) begin
      s[i] = a[i] ^ b[i] ^ c;
      c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch sequencer: owns the PC, issues one memory request at a
// time, buffers the response for decode and handles redirect/halt.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = 16'h0000
)
(
  input  logic               clk,
  input  logic               rst,
  fetch_ctrl_if.master       mem,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_addr,
  input  logic               halt,
  input  logic               stall_d,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic [ADDR_W-1:0]  pc_inc,
  output logic               err
);

  fetch_state_e       state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [ADDR_W-1:0]  req_addr_q, req_addr_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0]  instr_pc_q, instr_pc_d;
  logic [ADDR_W-1:0]  pc_inc_q, pc_inc_d;
  logic               squash_q, squash_d;
  logic               err_q, err_d;
  logic               mem_req_c;
  logic [ADDR_W-1:0]  inc_sum;

  fulladder16 u_inc (
    .a  (req_addr_q),
    .b  (PC_INC),
    .ci (1'b0),
    .s  (inc_sum)
  );

  // Request is masked while reset is held so a freshly reset FETCH state does not issue.
  assign mem_req_c    = rst && (state_q == S_FETCH || state_q == S_DRAIN);
  assign mem.mem_req  = mem_req_c;
  assign mem.mem_addr = req_addr_q;

  assign instr_valid = (state_q == S_VALID);
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign pc_inc      = pc_inc_q;
  assign err         = err_q;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_addr_d = req_addr_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    pc_inc_d   = pc_inc_q;
    squash_d   = squash_q;
    err_d      = err_q | (mem.mem_ack & ~mem_req_c) | (redirect_valid & redirect_addr[0]);

    case (state_q)
      S_FETCH: begin
        if (halt) begin
          state_d = mem.mem_ack ? S_HALT : S_DRAIN;
        end else if (redirect_valid) begin
          pc_d = redirect_addr;
          // A redirect coinciding with the ack re-requests immediately; otherwise the
          // in-flight response is marked for discard and mem_addr stays stable.
          if (mem.mem_ack) begin
            req_addr_d = redirect_addr;
            squash_d   = 1'b0;
          end else begin
            squash_d   = 1'b1;
          end
        end else if (mem.mem_ack) begin
          if (squash_q) begin
            squash_d   = 1'b0;
            req_addr_d = pc_q;
          end else begin
            instr_d    = mem.mem_rdata;
            instr_pc_d = req_addr_q;
            pc_inc_d   = inc_sum;
            state_d    = S_VALID;
          end
        end
      end
      S_VALID: begin
        if (halt) begin
          state_d = S_HALT;
        end else if (redirect_valid) begin
          pc_d       = redirect_addr;
          req_addr_d = redirect_addr;
          state_d    = S_FETCH;
        end else if (!stall_d) begin
          pc_d       = pc_inc_q;
          req_addr_d = pc_inc_q;
          state_d    = S_FETCH;
        end
      end
      S_DRAIN: begin
        if (mem.mem_ack) begin
          state_d = S_HALT;
        end
      end
      S_HALT: begin
      end
      default: begin
        state_d = S_HALT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_FETCH;
      pc_q       <= RESET_PC;
      req_addr_q <= RESET_PC;
      instr_q    <= '0;
      instr_pc_q <= '0;
      pc_inc_q   <= PC_INC;
      squash_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_addr_q <= req_addr_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      pc_inc_q   <= pc_inc_d;
      squash_q   <= squash_d;
      err_q      <= err_d;
    end
  end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Sequencing controller for instruction fetch against a variable-latency, request/acknowledge instruction memory. Owns the architectural PC, issues one memory request at a time, buffers the returned instruction for decode, and handles decode back-pressure, branch/jump redirects and halt. Sits between the instruction memory port and the decode stage.

## Interface
- RESET_PC, 16'h0000, PC loaded on reset.
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  reset. Synchronous and active-low: sampled on the rising edge of clk, and rst==0 resets the block.
- redirect_valid  in  1  decode requests PC redirect this cycle.
- redirect_addr  in  16  redirect target.
- halt  in  1  halt request from decode.
- stall_d  in  1  decode cannot accept the presented instruction.
- mem_req  out  1  memory request.
- mem_addr  out  16  request address; stable while mem_req=1.
- mem_ack  in  1  single-cycle response pulse.
- mem_rdata  in  16  instruction word; valid when mem_ack=1.
- instr_valid  out  1  instr/instr_pc/pc_inc valid for decode.
- instr  out  16  buffered instruction.
- instr_pc  out  16  address of instr.
- pc_inc  out  16  instr_pc + 2, modulo 2^16.
- err  out  1  sticky protocol error.

## Operation
- States:
  - FETCH: mem_req=1, waiting for ack.
  - VALID: instruction presented.
  - DRAIN: halt pending; outstanding request completing.
  - HALT: terminal.
- Registers:
  - pc: next fetch address.
  - req_addr: drives mem_addr.
  - squash flag.
  - instruction buffer.
- FETCH entry loads req_addr<=pc. mem_req stays high up to and including the ack cycle.
- FETCH + mem_ack, squash=0: buffer<=mem_rdata, instr_pc<=req_addr, go to VALID.
- FETCH + mem_ack, squash=1: drop data, clear squash, stay in FETCH. Re-request at pc; mem_addr changes the cycle after the ack.
- FETCH + redirect_valid, no ack: pc<=redirect_addr, squash<=1. mem_addr is not altered.
- FETCH + redirect_valid in the same cycle as mem_ack: response dropped, next request at redirect_addr.
- VALID, stall_d=0: instruction accepted; pc<=instr_pc+2, go to FETCH.
- VALID, stall_d=1: outputs held unchanged.
- VALID + redirect_valid: buffered instruction dropped regardless of stall_d; pc<=redirect_addr, go to FETCH.
- halt has priority over redirect_valid in every state.
  - In VALID: go to HALT.
  - In FETCH: go to DRAIN. With ack in the same cycle, go to HALT directly and drop the data.
- DRAIN: mem_req held until ack, data dropped, then HALT.
- HALT: mem_req=0, instr_valid=0 until reset.
- Address arithmetic is 16-bit and wraps: 16'hFFFE+2 = 16'h0000.
- err is set by either of:
  - mem_ack while mem_req=0.
  - redirect_valid with redirect_addr[0]=1; the redirect is still taken.
- err clears only on reset.

## Timing
- Reset values: state=FETCH with mem_req=0 during the reset cycle; pc=req_addr=RESET_PC; instr_valid=0; instr=instr_pc=0; pc_inc=2; err=0; squash=0.
- First cycle with rst=1: mem_req=1, mem_addr=RESET_PC.
- mem_ack arrives at the earliest in the cycle after mem_req rises. With ack at cycle k, instr_valid=1 at k+1.
- Best-case throughput: one instruction per 3 cycles (request, ack, present/accept).
- instr_valid and all data outputs are registered. Nothing combinational passes from input to output except none.
- Reset asserted mid-request: state is abandoned. A later stale mem_ack is ignored if it arrives while mem_req=0 in the reset cycle, and it raises err only after reset is released.

## Structure
- Shared header fetch_ctrl_defs.vh:
  - 2-bit state encodings FETCH=0, VALID=1, DRAIN=2, HALT=3.
  - Instruction width 16.
  - PC increment constant 2.
- One sub-module: the existing fulladder16, used for instr_pc+2.
- Flops built from dff.

## Test plan
- Reset, then ack after 1 cycle with rdata=16'h1234, stall_d=0 → instr_valid at cycle 3, instr=16'h1234, instr_pc=0, pc_inc=2; next mem_addr=2.
- Ack with rdata=16'hA5A5, then stall_d=1 for 4 cycles → outputs constant for 4 cycles, mem_req=0; after release, next mem_addr=instr_pc+2.
- redirect_valid with addr=16'h0040, 2 cycles before a 4-cycle-latency ack → mem_addr holds old address until ack, data dropped, instr_valid stays 0, next mem_addr=16'h0040.
- halt during FETCH → DRAIN, mem_req held until ack, data dropped, HALT; no further mem_req; redirect ignored.
- Fetch at pc=16'hFFFE → pc_inc=0, next mem_addr=0.
- Spurious mem_ack in HALT, or redirect to odd address 16'h0011 → err=1 and remains 1 until reset.
